// File: rtl/bcd_scan_pkg.sv
// ---------------------------------------------------------------------------
// bcd_scan_pkg
// Shared constants and helpers for the BCD counter / display scanner.
//   BCD_MAX       largest legal BCD digit value
//   DIGIT_BLANK   code sent to the seven-segment decoder for a dark digit
//   presc_width() register width needed to count 0..div-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package bcd_scan_pkg;

    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/bcd_count_scan_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One BCD digit (0..9) with increment, decrement and synchronous clear.
//   clk, rst   clock, asynchronous active-high reset
//   clr        synchronous clear, wins over inc/dec
//   inc, dec   step this digit up / down (mutually exclusive by construction)
//   digit      current BCD value
//   carry      inc while at 9: digit rolls to 0, next digit must increment
//   borrow     dec while at 0: digit rolls to 9, next digit must decrement
// ---------------------------------------------------------------------------
module bcd_digit
    import bcd_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] digit,
    output logic       carry,
    output logic       borrow
);

    // Combinational so a ripple across all digits resolves in one step cycle.
    assign carry  = inc && (digit == BCD_MAX);
    assign borrow = dec && (digit == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (inc) begin
            digit <= carry ? 4'd0 : digit + 4'd1;
        end else if (dec) begin
            digit <= borrow ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_count_scan.sv
// ---------------------------------------------------------------------------
// bcd_count_scan
// Multi-digit BCD up/down counter driving a time-multiplexed display.
//   clk    system clock
//   rst    asynchronous active-high reset
//   en     count enable (prescaler runs and steps apply only while high)
//   up     direction: 1 = increment, 0 = decrement
//   clr    synchronous clear of count, count prescaler and wrap
//   count  full BCD value, digit 0 in bits [3:0]
//   wrap   one-cycle pulse coinciding with the wrapped count value
//   AN     active-low digit select, exactly one bit low
//   Q      BCD code of the selected digit, 4'hF when blanked
// ---------------------------------------------------------------------------
module bcd_count_scan
    import bcd_scan_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [DIGITS-1:0]     AN,
    output logic [3:0]            Q
);

    localparam int TW = presc_width(TICK_DIV);
    localparam int SW = presc_width(SCAN_DIV);
    localparam int IW = presc_width(DIGITS);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    // ---------------- count prescaler ----------------
    logic [TW-1:0] tick_cnt;
    logic          step;

    assign step = en && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= step ? '0 : tick_cnt + TW'(1);
        end
    end

    // ---------------- digit chain ----------------
    // inc_c/dec_c[i] steps digit i; the top entry is the carry/borrow out of
    // the most significant digit, which is exactly the wrap condition.
    logic [DIGITS:0] inc_c;
    logic [DIGITS:0] dec_c;

    assign inc_c[0] = step && up;
    assign dec_c[0] = step && !up;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .inc    (inc_c[g]),
            .dec    (dec_c[g]),
            .digit  (count[4*g +: 4]),
            .carry  (inc_c[g+1]),
            .borrow (dec_c[g+1])
        );
    end

    // Registered alongside the digits so it is high while count shows the
    // wrapped value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
        end else if (clr) begin
            wrap <= 1'b0;
        end else begin
            wrap <= inc_c[DIGITS] || dec_c[DIGITS];
        end
    end

    // ---------------- display scan ----------------
    logic [SW-1:0]     scan_cnt;
    logic              scan_adv;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nxt;
    logic [DIGITS-1:0] upper_zero;
    logic [3:0]        sel_digit;
    logic              sel_blank;
    logic [3:0]        q_nxt;

    assign scan_adv = (scan_cnt == SCAN_LAST);

    always_comb begin
        idx_nxt = idx;
        if (scan_adv) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    // upper_zero[i]: digits i..DIGITS-1 are all zero (leading-zero run).
    always_comb begin
        upper_zero = '0;
        upper_zero[DIGITS-1] = (count[4*(DIGITS-1) +: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (count[4*i +: 4] == 4'd0);
        end
    end

    // AN/Q are built from the index they are about to show so both change
    // on the same edge as the index itself.
    always_comb begin
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                sel_digit = count[4*i +: 4];
                sel_blank = (i != 0) && upper_zero[i];
            end
        end
        q_nxt = ((BLANK_LZ != 0) && sel_blank) ? DIGIT_BLANK : sel_digit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            AN       <= ~DIGITS'(1);
            Q        <= 4'h0;
        end else begin
            scan_cnt <= scan_adv ? '0 : scan_cnt + SW'(1);
            idx      <= idx_nxt;
            AN       <= ~(DIGITS'(1) << idx_nxt);
            Q        <= q_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_count_scan.sv
`timescale 1ns/1ps
module tb_bcd_count_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic up  = 1'b1;
    logic clr = 1'b0;

    logic [15:0] count4, count4n;
    logic [7:0]  count2;
    logic        wrap4, wrap4n, wrap2;
    logic [3:0]  an4, an4n;
    logic [1:0]  an2;
    logic [3:0]  q4, q4n, q2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bcd_count_scan #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)) u4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
        .count(count4), .wrap(wrap4), .AN(an4), .Q(q4));

    bcd_count_scan #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(0)) u4n (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
        .count(count4n), .wrap(wrap4n), .AN(an4n), .Q(q4n));

    bcd_count_scan #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
        .count(count2), .wrap(wrap2), .AN(an2), .Q(q2));

    typedef struct {
        logic        en;
        logic        up;
        logic        clr;
        int          ticks;
        logic [15:0] c4;
        logic [7:0]  c2;
        logic        w;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [3:0] q_lz;
        logic [3:0] q_nolz;
    } scan_t;

    vec_t  vt[17];
    scan_t st[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_count(input int steps);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        en  = 1'b1;
        up  = 1'b1;
        tick(4 * steps);
        en  = 1'b0;
    endtask

    initial begin
        logic       wseen;
        logic [3:0] prev;
        bit         synced;

        // count sequence after reset: 10 up steps, clear, down wrap, up wrap
        vt[0]  = '{1'b1, 1'b1, 1'b0, 4, 16'h0001, 8'h01, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 4, 16'h0002, 8'h02, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 4, 16'h0003, 8'h03, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 4, 16'h0004, 8'h04, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 4, 16'h0005, 8'h05, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 4, 16'h0006, 8'h06, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 4, 16'h0007, 8'h07, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 4, 16'h0008, 8'h08, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 4, 16'h0009, 8'h09, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 4, 16'h0010, 8'h10, 1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b1, 1, 16'h0000, 8'h00, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 4, 16'h9999, 8'h99, 1'b1};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1, 16'h9999, 8'h99, 1'b0};
        vt[13] = '{1'b1, 1'b0, 1'b0, 3, 16'h9998, 8'h98, 1'b0};
        vt[14] = '{1'b1, 1'b1, 1'b0, 4, 16'h9999, 8'h99, 1'b0};
        vt[15] = '{1'b1, 1'b1, 1'b0, 4, 16'h0000, 8'h00, 1'b1};
        vt[16] = '{1'b1, 1'b1, 1'b0, 1, 16'h0000, 8'h00, 1'b0};

        // scan of 0042: AN, Q with blanking, Q without blanking
        st[0] = '{4'b1110, 4'h2, 4'h2};
        st[1] = '{4'b1101, 4'h4, 4'h4};
        st[2] = '{4'b1011, 4'hF, 4'h0};
        st[3] = '{4'b0111, 4'hF, 4'h0};

        // reset state
        tick(2);
        chk("rst_count4", count4, 16'h0000);
        chk("rst_wrap4", wrap4, 1'b0);
        chk("rst_an4", an4, 4'b1110);
        chk("rst_q4", q4, 4'h0);
        chk("rst_an2", an2, 2'b10);
        chk("rst_q2", q2, 4'h0);

        rst = 1'b0;
        for (int v = 0; v < 17; v++) begin
            en    = vt[v].en;
            up    = vt[v].up;
            clr   = vt[v].clr;
            wseen = 1'b0;
            for (int t = 0; t < vt[v].ticks - 1; t++) begin
                tick(1);
                wseen = wseen | wrap4 | wrap4n | wrap2;
            end
            tick(1);
            chk($sformatf("vec%0d_wrap_between", v), wseen, 1'b0);
            chk($sformatf("vec%0d_count4", v), count4, vt[v].c4);
            chk($sformatf("vec%0d_count4n", v), count4n, vt[v].c4);
            chk($sformatf("vec%0d_count2", v), count2, vt[v].c2);
            chk($sformatf("vec%0d_wrap4", v), wrap4, vt[v].w);
            chk($sformatf("vec%0d_wrap2", v), wrap2, vt[v].w);
        end
        clr = 1'b0;

        // clear coinciding with a step at 0042
        set_count(42);
        chk("clr_pre_count", count4, 16'h0042);
        en = 1'b1;
        tick(3);
        chk("clr_hold_count", count4, 16'h0042);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_step_count", count4, 16'h0000);
        chk("clr_step_wrap", wrap4, 1'b0);
        tick(3);
        chk("clr_after3_count", count4, 16'h0000);
        tick(1);
        chk("clr_after4_count", count4, 16'h0001);

        // scan of a held 0042
        set_count(42);
        chk("scan_count", count4, 16'h0042);
        synced = 1'b0;
        for (int t = 0; t < 20 && !synced; t++) begin
            prev = an4;
            tick(1);
            if (an4 == 4'b1110 && prev != 4'b1110) synced = 1'b1;
        end
        chk("scan_sync", synced, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("scan%0d_an4", k), an4, st[(k/2)%4].an);
            chk($sformatf("scan%0d_an4n", k), an4n, st[(k/2)%4].an);
            chk($sformatf("scan%0d_q_lz", k), q4, st[(k/2)%4].q_lz);
            chk($sformatf("scan%0d_q_nolz", k), q4n, st[(k/2)%4].q_nolz);
            tick(1);
        end

        // asynchronous reset mid-dwell at 0123
        set_count(123);
        chk("arst_pre_count", count4, 16'h0123);
        tick(1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count4", count4, 16'h0000);
        chk("arst_count2", count2, 8'h00);
        chk("arst_wrap4", wrap4, 1'b0);
        chk("arst_an4", an4, 4'b1110);
        chk("arst_q4", q4, 4'h0);
        chk("arst_an2", an2, 2'b10);
        tick(1);
        chk("arst_hold_wrap", wrap4 | wrap4n | wrap2, 1'b0);
        rst = 1'b0;
        tick(1);
        chk("arst_resume_an0", an4, 4'b1110);
        chk("arst_resume_q0", q4, 4'h0);
        tick(1);
        chk("arst_resume_an1", an4, 4'b1101);
        chk("arst_resume_q1_lz", q4, 4'hF);
        chk("arst_resume_q1_nolz", q4n, 4'h0);
        chk("arst_resume_wrap", wrap4 | wrap4n | wrap2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_count_scan.md
Name: bcd_count_scan

Overview:
- Multi-digit BCD up/down counter with time-multiplexed display scan.
- Produces one 4-bit BCD code at a time (Q) plus an active-low digit-select (AN).
- Q connects directly to the per-digit BCD-to-seven-segment decoder. That decoder maps 0-9 to glyphs and every other code to all segments off.
- Sits between the board controls (enable, direction, clear) and the display decoder.

Parameters:
- DIGITS, 4, number of BCD digits counted and scanned (2..8).
- TICK_DIV, 100000000, clk cycles per count step (1 Hz at 100 MHz).
- SCAN_DIV, 100000, clk cycles per digit dwell (1 kHz digit rate at 100 MHz).
- BLANK_LZ, 1, when 1 leading zeros are blanked.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; the prescaler runs and steps apply only while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on the step cycle.
- clr  input  1  synchronous clear of count and count prescaler.
- count  output  4*DIGITS  full BCD value; digit 0 is bits [3:0].
- wrap  output  1  one-cycle pulse on 99..9->0 (up) or 0->99..9 (down).
- AN  output  DIGITS  digit select, active low, exactly one bit low.
- Q  output  4  BCD code of the selected digit, or 4'hF when blanked.

Behaviour:
- Reset (async, rst=1):
  - count = 0, wrap = 0, both prescalers = 0, scan index = 0.
  - AN = all ones except bit 0 low; Q = 4'h0.
- Count prescaler:
  - Increments each cycle while en=1; holds while en=0.
  - At TICK_DIV-1 it returns to 0 and asserts an internal step for that cycle.
- Step:
  - Up: digit 0 increments; a digit at 9 goes to 0 and carries to the next digit.
  - Down: digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - count updates the cycle after the step cycle.
  - wrap is high for exactly the cycle in which count shows the wrapped value.
- clr:
  - Has priority over step in the same cycle: count <= 0, prescaler <= 0, wrap <= 0.
  - Does not touch the scan logic.
- Illegal digit codes (A-F) never arise from the counter's own stepping; no handling is required.
- Scan:
  - The scan prescaler runs continuously, independent of en and clr.
  - At SCAN_DIV-1 the scan index advances, wrapping from DIGITS-1 to 0.
  - AN and Q are registered and change in the same cycle.
  - AN bit i is low iff index = i.
  - Q = digit[index], or 4'hF if BLANK_LZ=1, index != 0, and digits index..DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - Q/AN reflect count as registered; a one-cycle lag after a count change is acceptable.
- Reset mid-count or mid-scan returns everything to reset values immediately, with no glitch pulse on wrap.
- Arithmetic: prescalers are sized ceil(log2(DIV)) bits; no BCD digit exceeds 9 in any reachable state.

Decomposition:
- Package bcd_scan_pkg:
  - BCD_MAX = 4'd9.
  - DIGIT_BLANK = 4'hF.
  - Function for the prescaler width.
- Sub-module bcd_digit: one 4-bit BCD digit with inc/dec/clr and carry/borrow out. Instantiated DIGITS times in a generate chain.
- Scan and prescaler logic stays in the top.

Test Plan (TICK_DIV=4, SCAN_DIV=2, DIGITS=4 unless stated):
- Reset release, en=1, up=1, 40 cycles:
  - count steps every 4 cycles: 0000, 0001, ... 0010.
  - 0009->0010 carry is correct; wrap stays 0.
- Preload via 9999 up-steps, or DIGITS=2 reaching 99, then one more up step:
  - count = 00 and wrap high for exactly 1 cycle.
- From 0000 with up=0:
  - first step gives 9999 (DIGITS=4) and a wrap pulse.
  - next step gives 9998, wrap low.
- clr asserted on the same cycle as a step at count=0042:
  - next count = 0000 and wrap = 0.
  - next step occurs 4 cycles after clr deasserts.
- count=0042 held (en=0), observe 8 scan dwells:
  - AN cycles 1110, 1101, 1011, 0111, every 2 cycles.
  - Q = 2, 4, F, F with BLANK_LZ=1; Q = 2, 4, 0, 0 with BLANK_LZ=0.
- rst pulsed asynchronously mid-dwell at count=0123:
  - Outputs go to reset values before the next clk edge.
  - No wrap pulse; scanning resumes at digit 0.
